// File: rtl/lbdr_dr_router.sv
// LBDR routing unit with deroute fallback, one per router input port.
// Computes a one-hot output-port request from a packet's HEADER flit and
// holds it until the TAIL flit is read by the switch allocator. Protocol
// violations and unroutable packets raise a sticky error flag.

`ifndef HEADER
`define HEADER 3'b001
`endif
`ifndef PAYLOAD
`define PAYLOAD 3'b010
`endif
`ifndef TAIL
`define TAIL 3'b100
`endif

module lbdr_dr_router #(
  parameter int unsigned X_W        = 32'd2,
  parameter int unsigned Y_W        = 32'd2,
  parameter bit          DEROUTE_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         Rxy_rst,
  input  logic [3:0]         Cx_rst,
  input  logic [1:0]         Dr_rst,
  input  logic [X_W+Y_W-1:0] cur_addr_rst,
  input  logic               empty,
  input  logic [2:0]         flit_id,
  input  logic [X_W+Y_W-1:0] dst_addr,
  input  logic               flit_rd,
  output logic               Nport,
  output logic               Eport,
  output logic               Wport,
  output logic               Sport,
  output logic               Lport,
  output logic               route_valid,
  output logic               err
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ROUTED = 1'b1
  } state_t;

  // Port vector bit order: 0 N, 1 E, 2 W, 3 S, 4 L (matches Cx/Dr encoding).
  state_t               r_state;
  logic [7:0]           r_rxy;
  logic [3:0]           r_cx;
  logic [1:0]           r_dr;
  logic [X_W+Y_W-1:0]   r_cur_addr;
  logic [4:0]           r_ports;
  logic                 r_route_valid;
  logic                 r_err;

  logic [X_W-1:0]       w_x_cur;
  logic [X_W-1:0]       w_x_dst;
  logic [Y_W-1:0]       w_y_cur;
  logic [Y_W-1:0]       w_y_dst;
  logic                 w_n1;
  logic                 w_e1;
  logic                 w_w1;
  logic                 w_s1;
  logic                 w_local;
  logic [3:0]           w_min;
  logic [3:0]           w_dr_onehot;
  logic [3:0]           w_req4;
  logic [4:0]           w_req;
  logic                 w_unroutable;

  state_t               w_next_state;
  logic [4:0]           w_next_ports;
  logic                 w_next_route_valid;
  logic                 w_next_err;

  assign w_x_cur = r_cur_addr[X_W-1:0];
  assign w_y_cur = r_cur_addr[X_W+Y_W-1:X_W];
  assign w_x_dst = dst_addr[X_W-1:0];
  assign w_y_dst = dst_addr[X_W+Y_W-1:X_W];

  assign w_n1 = (w_y_dst < w_y_cur);
  assign w_s1 = (w_y_cur < w_y_dst);
  assign w_e1 = (w_x_cur < w_x_dst);
  assign w_w1 = (w_x_dst < w_x_cur);
  assign w_local = ~w_n1 & ~w_e1 & ~w_w1 & ~w_s1;

  // Minimal LBDR port set, each direction gated by its connectivity bit.
  always_comb begin
    w_min    = 4'b0000;
    w_min[0] = ((w_n1 & ~w_e1 & ~w_w1) | (w_n1 & w_e1 & r_rxy[0]) | (w_n1 & w_w1 & r_rxy[1])) & r_cx[0];
    w_min[1] = ((w_e1 & ~w_n1 & ~w_s1) | (w_e1 & w_n1 & r_rxy[2]) | (w_e1 & w_s1 & r_rxy[3])) & r_cx[1];
    w_min[2] = ((w_w1 & ~w_n1 & ~w_s1) | (w_w1 & w_n1 & r_rxy[4]) | (w_w1 & w_s1 & r_rxy[5])) & r_cx[2];
    w_min[3] = ((w_s1 & ~w_e1 & ~w_w1) | (w_s1 & w_e1 & r_rxy[6]) | (w_s1 & w_w1 & r_rxy[7])) & r_cx[3];
  end

  assign w_dr_onehot = 4'b0001 << r_dr;

  // Pick one direction: minimal set first (N>E>W>S so the request stays
  // one-hot even if routing bits allow two), deroute only when it is empty.
  always_comb begin
    w_req4 = 4'b0000;
    if (w_min[0]) begin
      w_req4 = 4'b0001;
    end else if (w_min[1]) begin
      w_req4 = 4'b0010;
    end else if (w_min[2]) begin
      w_req4 = 4'b0100;
    end else if (w_min[3]) begin
      w_req4 = 4'b1000;
    end else if (!w_local && DEROUTE_EN) begin
      w_req4 = w_dr_onehot & r_cx;
    end else begin
      w_req4 = 4'b0000;
    end
  end

  assign w_req        = {w_local, w_req4};
  assign w_unroutable = (w_req == 5'b00000);

  // Next-state and next-output logic for the IDLE/ROUTED packet FSM.
  always_comb begin
    w_next_state       = r_state;
    w_next_ports       = r_ports;
    w_next_route_valid = r_route_valid;
    w_next_err         = r_err;
    case (r_state)
      ST_IDLE: begin
        if (!empty) begin
          if (flit_id == `HEADER) begin
            if (w_unroutable) begin
              w_next_err = 1'b1;
            end else begin
              w_next_ports       = w_req;
              w_next_route_valid = 1'b1;
              w_next_state       = ST_ROUTED;
            end
          end else begin
            w_next_err = 1'b1;
          end
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_ROUTED: begin
        if (!empty) begin
          if (flit_id == `HEADER) begin
            w_next_err = 1'b1;
          end else if ((flit_id == `TAIL) && flit_rd) begin
            w_next_ports       = 5'b00000;
            w_next_route_valid = 1'b0;
            w_next_state       = ST_IDLE;
          end else begin
            w_next_state = ST_ROUTED;
          end
        end else begin
          w_next_state = ST_ROUTED;
        end
      end
      default: begin
        w_next_state       = ST_IDLE;
        w_next_ports       = 5'b00000;
        w_next_route_valid = 1'b0;
      end
    endcase
  end

  // State, configuration and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rxy         <= Rxy_rst;
      r_cx          <= Cx_rst;
      r_dr          <= Dr_rst;
      r_cur_addr    <= cur_addr_rst;
      r_state       <= ST_IDLE;
      r_ports       <= 5'b00000;
      r_route_valid <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_ports       <= w_next_ports;
      r_route_valid <= w_next_route_valid;
      r_err         <= w_next_err;
    end
  end

  assign Nport       = r_ports[0];
  assign Eport       = r_ports[1];
  assign Wport       = r_ports[2];
  assign Sport       = r_ports[3];
  assign Lport       = r_ports[4];
  assign route_valid = r_route_valid;
  assign err         = r_err;

endmodule

// File: tb/tb_lbdr_dr_router.sv
// Directed bench for lbdr_dr_router. Output vector compared each step is
// {Lport,Sport,Wport,Eport,Nport,route_valid,err}.

`ifndef HEADER
`define HEADER 3'b001
`endif
`ifndef PAYLOAD
`define PAYLOAD 3'b010
`endif
`ifndef TAIL
`define TAIL 3'b100
`endif

module tb_lbdr_dr_router;

  logic       clk;
  logic       rst;
  logic [7:0] rxy_rst;
  logic [3:0] cx_rst;
  logic [1:0] dr_rst;
  logic [3:0] cur_rst;
  logic       empty;
  logic [2:0] flit_id;
  logic [3:0] dst_addr;
  logic       flit_rd;

  logic n0, e0, w0, s0, l0, v0, err0;
  logic n1, e1, w1, s1, l1, v1, err1;

  int n_vec;
  int n_err;

  lbdr_dr_router #(.X_W(2), .Y_W(2), .DEROUTE_EN(1'b1)) u_dr (
    .clk(clk), .rst(rst), .Rxy_rst(rxy_rst), .Cx_rst(cx_rst), .Dr_rst(dr_rst),
    .cur_addr_rst(cur_rst), .empty(empty), .flit_id(flit_id), .dst_addr(dst_addr),
    .flit_rd(flit_rd), .Nport(n0), .Eport(e0), .Wport(w0), .Sport(s0), .Lport(l0),
    .route_valid(v0), .err(err0)
  );

  lbdr_dr_router #(.X_W(2), .Y_W(2), .DEROUTE_EN(1'b0)) u_min (
    .clk(clk), .rst(rst), .Rxy_rst(rxy_rst), .Cx_rst(cx_rst), .Dr_rst(dr_rst),
    .cur_addr_rst(cur_rst), .empty(empty), .flit_id(flit_id), .dst_addr(dst_addr),
    .flit_rd(flit_rd), .Nport(n1), .Eport(e1), .Wport(w1), .Sport(s1), .Lport(l1),
    .route_valid(v1), .err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected vectors {L,S,W,E,N,valid,err}
  localparam logic [6:0] V_IDLE = 7'b0000000;
  localparam logic [6:0] V_ERR  = 7'b0000001;
  localparam logic [6:0] V_N    = 7'b0000110;
  localparam logic [6:0] V_E    = 7'b0001010;
  localparam logic [6:0] V_W    = 7'b0010010;
  localparam logic [6:0] V_S    = 7'b0100010;
  localparam logic [6:0] V_L    = 7'b1000010;

  task automatic check_vec(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] out_dr();
    return {l0, s0, w0, e0, n0, v0, err0};
  endfunction

  function automatic logic [6:0] out_min();
    return {l1, s1, w1, e1, n1, v1, err1};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [7:0] rxy, input logic [3:0] cx,
                          input logic [1:0] dr, input logic [3:0] cur);
    rst = 1'b1; rxy_rst = rxy; cx_rst = cx; dr_rst = dr; cur_rst = cur;
    empty = 1'b1; flit_id = 3'b000; flit_rd = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic flit(input logic [2:0] id, input logic [3:0] dst, input logic rd);
    empty = 1'b0; flit_id = id; dst_addr = dst; flit_rd = rd;
    step();
  endtask

  task automatic idle_cycle();
    empty = 1'b1; flit_id = 3'b000; flit_rd = 1'b0;
    step();
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b0; rxy_rst = 8'h00; cx_rst = 4'h0; dr_rst = 2'b00; cur_rst = 4'h0;
    empty = 1'b1; flit_id = 3'b000; dst_addr = 4'h0; flit_rd = 1'b0;
    step();

    // Minimal routes from cur=5 (x=1,y=1)
    do_reset(8'h3C, 4'hF, 2'b11, 4'd5);
    check_vec("reset_dr", out_dr(), V_IDLE);
    check_vec("reset_min", out_min(), V_IDLE);
    flit(`HEADER, 4'd0, 1'b0);
    check_vec("min_dst0_W", out_dr(), V_W);
    flit(`TAIL, 4'd0, 1'b1);
    check_vec("tail_clear0", out_dr(), V_IDLE);
    flit(`HEADER, 4'd7, 1'b0);
    check_vec("min_dst7_E", out_dr(), V_E);
    flit(`TAIL, 4'd0, 1'b1);
    check_vec("tail_clear7", out_dr(), V_IDLE);
    flit(`HEADER, 4'd5, 1'b0);
    check_vec("min_dst5_L", out_dr(), V_L);
    flit(`TAIL, 4'd0, 1'b1);
    check_vec("tail_clear5", out_dr(), V_IDLE);
    flit(`HEADER, 4'd1, 1'b0);
    check_vec("min_dst1_N", out_dr(), V_N);
    flit(`TAIL, 4'd0, 1'b1);
    check_vec("tail_clear1", out_dr(), V_IDLE);

    // Hold across empty cycles, payload and unread tail
    flit(`HEADER, 4'd7, 1'b0);
    check_vec("hold_hdr", out_dr(), V_E);
    for (int i = 0; i < 3; i++) begin
      idle_cycle();
      check_vec("hold_empty", out_dr(), V_E);
    end
    flit(`PAYLOAD, 4'd0, 1'b1);
    check_vec("hold_payload", out_dr(), V_E);
    for (int i = 0; i < 2; i++) begin
      flit(`TAIL, 4'd0, 1'b0);
      check_vec("hold_tail_unread", out_dr(), V_E);
    end
    flit(`TAIL, 4'd0, 1'b1);
    check_vec("tail_read", out_dr(), V_IDLE);
    // Back-to-back header right after tail read
    flit(`HEADER, 4'd0, 1'b0);
    check_vec("b2b_W", out_dr(), V_W);

    // Header while routed: error, held port unchanged
    flit(`HEADER, 4'd7, 1'b0);
    check_vec("hdr_in_routed", out_dr(), V_W | V_ERR);
    flit(`TAIL, 4'd0, 1'b1);
    check_vec("err_sticky", out_dr(), V_ERR);

    // Payload in IDLE
    do_reset(8'h3C, 4'hF, 2'b11, 4'd5);
    check_vec("reset_clears_err", out_dr(), V_IDLE);
    flit(`PAYLOAD, 4'd0, 1'b1);
    check_vec("payload_idle", out_dr(), V_ERR);

    // Reset mid-packet, then new config (W link down, deroute S)
    do_reset(8'h3C, 4'hF, 2'b11, 4'd5);
    flit(`HEADER, 4'd7, 1'b0);
    check_vec("pre_midreset_E", out_dr(), V_E);
    empty = 1'b0; flit_id = `PAYLOAD; flit_rd = 1'b0;
    do_reset(8'h3C, 4'b1011, 2'b11, 4'd5);
    check_vec("midreset_dr", out_dr(), V_IDLE);
    check_vec("midreset_min", out_min(), V_IDLE);
    flit(`HEADER, 4'd4, 1'b0);
    check_vec("deroute_S", out_dr(), V_S);
    check_vec("noderoute_err", out_min(), V_ERR);

    // Deroute port itself blocked: unroutable
    do_reset(8'h3C, 4'b1011, 2'b10, 4'd5);
    flit(`HEADER, 4'd4, 1'b0);
    check_vec("unroutable", out_dr(), V_ERR);
    idle_cycle();
    check_vec("unroutable_idle", out_dr(), V_ERR);
    // Still IDLE: a routable header is accepted afterwards
    flit(`HEADER, 4'd7, 1'b0);
    check_vec("after_unroutable_E", out_dr(), V_E | V_ERR);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
